mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Shares the single-ported 1024x32 unified instruction/data memory between two requesters: the instruction-fetch (IF) port and the data (MEM-stage LW/SW) port.
- Sequences each access through a fixed issue/response FSM. Data has priority; a starvation guard protects fetch.
- Supports branch-taken flush of an in-flight fetch, and halt gating of new grants.

Parameters:
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data word width
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins one conflict (range 1..15)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, level; held until i_gnt
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  one-cycle fetch grant pulse
- i_rvalid  out  1  one-cycle fetch data-valid pulse
- i_rdata  out  DATA_W  fetched word, valid with i_rvalid
- d_req  in  1  data request, level; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle data grant pulse
- d_ack  out  1  one-cycle completion pulse for load or store
- d_rdata  out  DATA_W  load data, valid with d_ack when d_we was 0
- flush  in  1  branch taken: kill in-flight fetch response
- halt  in  1  processor halted: no new grants
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after mem_en

Behaviour:
- Reset: state IDLE; every output 0; starvation counter 0; owner 0.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - If halt=0 and any request is present, pick a winner.
  - Registered outputs: the winner's gnt=1 and mem_en=1; mem_we/mem_addr/mem_wdata take the winner's values (mem_we=0 for fetch).
  - Latch owner (I or D) and the access kind. Go to ISSUE.
  - Otherwise stay in IDLE with mem_en=0.
- ISSUE (memory samples the command this cycle):
  - gnt and mem_en drop to 0. Requests are not sampled. Go to RESP.
- RESP (mem_rdata valid this cycle):
  - Register the result. Fetch owner: i_rdata=mem_rdata and i_rvalid=1, unless killed. Data owner: d_ack=1; d_rdata=mem_rdata for loads, 0 for stores.
  - Go to IDLE.
- Timing: request visible in cycle 0 -> gnt in cycle 1 -> rvalid/ack in cycle 3. Throughput is one access per 3 cycles.
- Requesters must drop or change req on the cycle after gnt. req is ignored outside IDLE.
- Arbitration when both request in IDLE:
  - d wins, unless starve_cnt >= STARVE_LIMIT, in which case i wins.
  - A lone requester always wins.
- Starvation counter (4 bits, saturating at 15):
  - +1 each IDLE cycle where i_req=1 and d wins.
  - Cleared on i_gnt, or on any cycle with i_req=0.
- Flush:
  - flush=1 in ISSUE or RESP with owner=I sets kill; that fetch's i_rvalid is suppressed. kill clears on return to IDLE.
  - flush does not affect a data access.
  - flush in IDLE has no effect; a fetch granted that same cycle is the redirected fetch and completes normally.
- Halt:
  - halt=1 blocks grants in IDLE only. An in-flight access completes and delivers rvalid/ack.
  - Starvation counter holds while halted.
- Reset mid-access: the FSM returns to IDLE; no rvalid/ack is produced for the abandoned access. A store already sampled by memory in ISSUE is not undone.
- Addresses pass through unmodified at ADDR_W bits; no wrap or range logic.

Optional Feature:
- ARB_STATS_EN defined: adds outputs i_gnt_cnt, d_gnt_cnt and conflict_cnt (32-bit each). They increment on i_gnt, on d_gnt, and on each IDLE cycle with i_req&d_req&~halt respectively. They wrap at 2^32 and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg: FSM state enum (IDLE, ISSUE, RESP), owner enum (OWN_I, OWN_D), and the ADDR_W/DATA_W defaults. The package also holds the pipeline opcode/type constants.
- One natural sub-module, mips_arb_prio: combinational winner select plus the saturating starvation counter.

Test Plan:
- Mem[5]=32'hDEADBEEF; i_req with i_addr=5 at cycle 0 -> i_gnt at 1, mem_addr=5 at 1, i_rvalid=1 with i_rdata=32'hDEADBEEF at 3.
- d_req store d_addr=9 d_wdata=32'h12345678 and i_req simultaneously -> d_gnt first with mem_we=1 and d_ack; fetch granted at the next IDLE; a later load of 9 returns 32'h12345678.
- STARVE_LIMIT=2; d_req held continuously with i_req=1 -> two data grants, then i_gnt on the third arbitration; counter back to 0.
- Fetch granted at cycle 1, flush=1 at cycle 2 -> no i_rvalid at 3; a new i_req at cycle 3 is granted at 4.
- halt=1 during RESP of a load -> d_ack delivered; pending i_req receives no grant while halt=1, and is granted one cycle after halt drops.
- rst=1 during ISSUE of a fetch -> no i_rvalid; all outputs 0 the following cycle; the next i_req is granted normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory arbiter and pipeline.
package mips_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/mips_arb_prio.sv
// Winner select for the shared memory port: data first, fetch wins once it has
// been denied STARVE_LIMIT consecutive arbitrations.
module mips_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic win_i,
  output logic win_d
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (arb_en) begin
      if (i_req && (!d_req || cnt_q >= 4'(STARVE_LIMIT))) win_i = 1'b1;
      else if (d_req)                                     win_d = 1'b1;
    end
  end

  // Halted or busy cycles leave the count untouched unless fetch stops asking.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_req || win_i)               cnt_d = 4'd0;
    else if (win_d && cnt_q != 4'hF)   cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory (IDLE/ISSUE/RESP).
// Define ARB_STATS_EN to add grant and conflict counters.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              flush,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       i_gnt_cnt,
  output logic [31:0]       d_gnt_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic              kill_q, kill_d;
  logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic              i_rvalid_q, i_rvalid_d, d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              win_i, win_d;

  mips_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state_q == IDLE && !halt),
    .i_req  (i_req),
    .d_req  (d_req),
    .win_i  (win_i),
    .win_d  (win_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_i || win_d) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    kill_d      = 1'b0;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (win_d) begin
          d_gnt_d     = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          owner_d     = OWN_D;
          we_d        = d_we;
        end else if (win_i) begin
          i_gnt_d    = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = i_addr;
          owner_d    = OWN_I;
          we_d       = 1'b0;
        end
      end
      ISSUE: kill_d = kill_q || (flush && owner_q == OWN_I);
      RESP: begin
        // A flush arriving in the response cycle itself still kills the fetch.
        if (owner_q == OWN_I) begin
          if (!(kill_q || flush)) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = mem_rdata;
          end
        end else begin
          d_ack_d   = 1'b1;
          d_rdata_d = we_q ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_I;
      we_q        <= 1'b0;
      kill_q      <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      we_q        <= we_d;
      kill_q      <= kill_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_STATS_EN
  logic [31:0] i_gnt_cnt_q, i_gnt_cnt_d;
  logic [31:0] d_gnt_cnt_q, d_gnt_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    i_gnt_cnt_d    = i_gnt_cnt_q + {31'd0, i_gnt_q};
    d_gnt_cnt_d    = d_gnt_cnt_q + {31'd0, d_gnt_q};
    conflict_cnt_d = conflict_cnt_q +
                     {31'd0, (state_q == IDLE) && i_req && d_req && !halt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_gnt_cnt_q    <= '0;
      d_gnt_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      i_gnt_cnt_q    <= i_gnt_cnt_d;
      d_gnt_cnt_q    <= d_gnt_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign i_gnt_cnt    = i_gnt_cnt_q;
  assign d_gnt_cnt    = d_gnt_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios, a per-cycle reference model
// of the arbitration rules, and a synchronous memory behind the arbiter.
module tb_mips_mem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, flush, halt;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_ack, mem_en, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int n_chk = 0;
  int n_pass = 0;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .flush(flush), .halt(halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter and an independent copy for the model
  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: tracks the access in flight by cycles since its grant
  int            since_gnt = -1;
  int            starve = 0;
  bit            m_own_d, m_we, killed;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            e_zero = 1'b1;
  bit            e_ig, e_dg, e_en, e_rv, e_ack;
  logic [DW-1:0] e_ird, e_drd;

  always @(posedge clk) begin
    e_ig = 0; e_dg = 0; e_en = 0; e_rv = 0; e_ack = 0;
    if (rst) begin
      since_gnt = -1;
      starve    = 0;
      killed    = 0;
      e_zero    = 1;
    end else begin
      e_zero = 0;
      if (since_gnt < 0) begin
        if (!halt && (i_req || d_req)) begin
          m_own_d = d_req && !(i_req && starve >= LIMIT);
          if (m_own_d) begin
            e_dg = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
            if (d_we) ref_mem[d_addr] = d_wdata;
            if (i_req && starve < 15) starve++;
          end else begin
            e_ig = 1; m_we = 0; m_addr = i_addr; starve = 0;
          end
          e_en = 1; killed = 0; since_gnt = 1;
        end
      end else if (since_gnt == 1) begin
        if (flush && !m_own_d) killed = 1;
        since_gnt = 2;
      end else begin
        if (m_own_d) begin
          e_ack = 1;
          e_drd = m_we ? '0 : ref_mem[m_addr];
        end else begin
          e_rv  = !(killed || flush);
          e_ird = ref_mem[m_addr];
        end
        since_gnt = -1;
      end
      if (!i_req) starve = 0;
    end
  end

  always @(negedge clk) begin
    if (e_zero) begin
      chk("rst_ctl", {i_gnt, i_rvalid, d_gnt, d_ack, mem_en, mem_we, mem_addr}, 64'd0);
      chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
    end else begin
      chk("m_i_gnt", i_gnt, e_ig);
      chk("m_d_gnt", d_gnt, e_dg);
      chk("m_mem_en", mem_en, e_en);
      chk("m_i_rvalid", i_rvalid, e_rv);
      chk("m_d_ack", d_ack, e_ack);
      if (e_en) begin
        chk("m_mem_we", mem_we, m_own_d && m_we);
        chk("m_mem_addr", mem_addr, m_addr);
        if (m_own_d && m_we) chk("m_mem_wdata", mem_wdata, m_wdata);
      end
      if (e_rv)  chk("m_i_rdata", i_rdata, e_ird);
      if (e_ack) chk("m_d_rdata", d_rdata, e_drd);
    end
  end

  initial begin
    int ngd;
    bit got;
    for (int k = 0; k < 1024; k++) begin
      mem[k]     = 32'hC0DE0000 | k;
      ref_mem[k] = 32'hC0DE0000 | k;
    end
    mem[5]     = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    mem_rdata = '0;
    rst = 1; i_req = 0; d_req = 0; d_we = 0; flush = 0; halt = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    chk("reset_outputs", {i_gnt, i_rvalid, d_gnt, d_ack, mem_en, mem_we}, 64'd0);
    rst = 0;
    tick(); tick();

    // Single fetch: gnt at +1, rvalid at +3
    i_req = 1; i_addr = 10'd5;
    tick(); chk("fetch_gnt", i_gnt, 1); chk("fetch_addr", mem_addr, 5); chk("fetch_en", mem_en, 1);
    i_req = 0;
    tick(); tick();
    chk("fetch_rvalid", i_rvalid, 1); chk("fetch_rdata", i_rdata, 32'hDEADBEEF);

    // Store and fetch together: data first, then fetch, then load back
    d_req = 1; d_we = 1; d_addr = 10'd9; d_wdata = 32'h12345678; i_req = 1; i_addr = 10'd7;
    tick(); chk("st_dgnt", d_gnt, 1); chk("st_igrant_lost", i_gnt, 0); chk("st_we", mem_we, 1);
    d_req = 0; d_we = 0;
    tick(); tick(); chk("st_ack", d_ack, 1);
    tick(); chk("st_then_fetch", i_gnt, 1);
    i_req = 0;
    tick(); tick();
    chk("fetch7_rdata", i_rdata, 32'hC0DE0007);
    d_req = 1; d_addr = 10'd9;
    tick(); chk("ld_gnt", d_gnt, 1);
    d_req = 0;
    tick(); tick(); chk("ld_ack", d_ack, 1); chk("ld_data", d_rdata, 32'h12345678);

    // Starvation: two data grants then fetch wins, then data wins again
    d_req = 1; d_we = 0; d_addr = 10'd3; i_req = 1; i_addr = 10'd4;
    ngd = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (d_gnt) ngd++;
      if (i_gnt) got = 1;
    end
    chk("starve_igrant_seen", got, 1);
    chk("starve_dgrants", ngd, 2);
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      if (d_gnt || i_gnt) got = 1;
    end
    chk("starve_cleared_dwins", d_gnt, 1);
    d_req = 0; i_req = 0;
    repeat (4) tick();

    // Flush kills the in-flight fetch; next fetch proceeds
    i_req = 1; i_addr = 10'd5;
    tick(); chk("fl_gnt", i_gnt, 1);
    i_req = 0;
    tick(); flush = 1;
    tick(); flush = 0; chk("fl_killed", i_rvalid, 0);
    i_req = 1; i_addr = 10'd6;
    tick(); chk("fl_next_gnt", i_gnt, 1);
    i_req = 0;
    tick(); tick(); chk("fl_next_rv", i_rvalid, 1); chk("fl_next_data", i_rdata, 32'hC0DE0006);

    // Halt during a load response: ack still delivered, fetch held off
    d_req = 1; d_addr = 10'd9;
    tick(); chk("h_dgnt", d_gnt, 1);
    d_req = 0; i_req = 1; i_addr = 10'd5;
    tick(); halt = 1;
    tick(); chk("h_ack", d_ack, 1); chk("h_data", d_rdata, 32'h12345678); chk("h_block0", i_gnt, 0);
    tick(); chk("h_block1", i_gnt, 0);
    tick(); chk("h_block2", i_gnt, 0);
    halt = 0;
    tick(); chk("h_release", i_gnt, 1);
    i_req = 0;
    tick(); tick(); chk("h_fetch_data", i_rdata, 32'hDEADBEEF);

    // Reset during ISSUE of a fetch
    i_req = 1; i_addr = 10'd5;
    tick(); chk("r_gnt", i_gnt, 1);
    i_req = 0; rst = 1;
    tick(); rst = 0;
    chk("r_outputs_zero", {i_gnt, i_rvalid, d_gnt, d_ack, mem_en, mem_we, mem_addr}, 64'd0);
    i_req = 1; i_addr = 10'd6;
    tick(); chk("r_regrant", i_gnt, 1); chk("r_no_rvalid", i_rvalid, 0);
    i_req = 0;
    tick(); tick(); chk("r_rv", i_rvalid, 1); chk("r_data", i_rdata, 32'hC0DE0006);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
